// File: rtl/gpio_bus_arb.sv
// Two-host round-robin arbiter in front of the gpio register port, with write-ack generation.
// Optional grant lock for atomic read-modify-write: define GPIO_ARB_LOCK_EN.
module gpio_bus_arb #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             host_req_i,
    input  logic [2*AddrWidth-1:0] host_addr_i,
    input  logic [1:0]             host_we_i,
    input  logic [7:0]             host_be_i,
    input  logic [2*DataWidth-1:0] host_wdata_i,
`ifdef GPIO_ARB_LOCK_EN
    input  logic [1:0]             host_lock_i,
`endif
    output logic [1:0]             host_gnt_o,
    output logic [1:0]             host_rvalid_o,
    output logic [DataWidth-1:0]   host_rdata_o,
    output logic                   device_req_o,
    output logic [AddrWidth-1:0]   device_addr_o,
    output logic                   device_we_o,
    output logic [3:0]             device_be_o,
    output logic [DataWidth-1:0]   device_wdata_o,
    input  logic                   device_rvalid_i,
    input  logic [DataWidth-1:0]   device_rdata_i
);

    logic prio_q, prio_d;
    logic rsp_pend_q, rsp_pend_d;
    logic rsp_host_q, rsp_host_d;
    logic rsp_we_q, rsp_we_d;
    logic [1:0] elig;
    logic gnt_idx;
    logic any_gnt;

`ifdef GPIO_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic lock_host_q, lock_host_d;
    logic lock_hold;

    // A lock only survives the cycle while its owner keeps host_lock_i high.
    assign lock_hold = lock_q & host_lock_i[lock_host_q];
`endif

    always_comb begin
        elig = rst_i ? 2'b00 : host_req_i;
`ifdef GPIO_ARB_LOCK_EN
        if (lock_hold) begin
            if (lock_host_q) elig[0] = 1'b0;
            else             elig[1] = 1'b0;
        end
`endif
        host_gnt_o = 2'b00;
        gnt_idx    = 1'b0;
        case (elig)
            2'b01: begin
                host_gnt_o = 2'b01;
                gnt_idx    = 1'b0;
            end
            2'b10: begin
                host_gnt_o = 2'b10;
                gnt_idx    = 1'b1;
            end
            2'b11: begin
                host_gnt_o = prio_q ? 2'b10 : 2'b01;
                gnt_idx    = prio_q;
            end
            default: begin
                host_gnt_o = 2'b00;
                gnt_idx    = 1'b0;
            end
        endcase
    end

    assign any_gnt = |host_gnt_o;

    always_comb begin
        device_req_o   = any_gnt;
        device_addr_o  = '0;
        device_we_o    = 1'b0;
        device_be_o    = 4'h0;
        device_wdata_o = '0;
        if (any_gnt) begin
            device_addr_o  = gnt_idx ? host_addr_i[AddrWidth +: AddrWidth]
                                     : host_addr_i[0 +: AddrWidth];
            device_we_o    = gnt_idx ? host_we_i[1] : host_we_i[0];
            device_be_o    = gnt_idx ? host_be_i[7:4] : host_be_i[3:0];
            device_wdata_o = gnt_idx ? host_wdata_i[DataWidth +: DataWidth]
                                     : host_wdata_i[0 +: DataWidth];
        end
    end

    always_comb begin
        prio_d     = any_gnt ? ~gnt_idx : prio_q;
        rsp_pend_d = any_gnt;
        rsp_host_d = gnt_idx;
        rsp_we_d   = device_we_o;
    end

`ifdef GPIO_ARB_LOCK_EN
    always_comb begin
        lock_d      = lock_hold;
        lock_host_d = lock_host_q;
        if (any_gnt && host_lock_i[gnt_idx]) begin
            lock_d      = 1'b1;
            lock_host_d = gnt_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q      <= 1'b0;
            lock_host_q <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            lock_host_q <= lock_host_d;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q     <= 1'b0;
            rsp_pend_q <= 1'b0;
            rsp_host_q <= 1'b0;
            rsp_we_q   <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_host_q <= rsp_host_d;
            rsp_we_q   <= rsp_we_d;
        end
    end

    // The device never acks writes, so the write response is synthesised here.
    always_comb begin
        host_rvalid_o = 2'b00;
        host_rdata_o  = '0;
        if (rsp_pend_q) begin
            if (rsp_we_q) begin
                host_rvalid_o[rsp_host_q] = 1'b1;
            end else if (device_rvalid_i) begin
                host_rvalid_o[rsp_host_q] = 1'b1;
                host_rdata_o              = device_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Scoreboard bench for gpio_bus_arb: directed scenarios then random traffic against a
// transaction-level model; lock scenarios are exercised when GPIO_ARB_LOCK_EN is defined.
module tb_gpio_bus_arb;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef GPIO_ARB_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req = '0;
    logic [2*AW-1:0] addr = '0;
    logic [1:0]      we = '0;
    logic [7:0]      be = '0;
    logic [2*DW-1:0] wdata = '0;
    logic [1:0]      lock = '0;
    logic [1:0]      gnt;
    logic [1:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            dreq;
    logic [AW-1:0]   daddr;
    logic            dwe;
    logic [3:0]      dbe;
    logic [DW-1:0]   dwdata;
    logic            drvalid = 1'b0;
    logic [DW-1:0]   drdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]    vld;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    // Reference state: whose turn it is under contention, who holds the lock, last transfer.
    int turn      = 0;
    int lock_host = -1;
    int last_host = -1;
    bit last_we   = 1'b0;

    gpio_bus_arb #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .host_req_i     (req),
        .host_addr_i    (addr),
        .host_we_i      (we),
        .host_be_i      (be),
        .host_wdata_i   (wdata),
`ifdef GPIO_ARB_LOCK_EN
        .host_lock_i    (lock),
`endif
        .host_gnt_o     (gnt),
        .host_rvalid_o  (rvalid),
        .host_rdata_o   (rdata),
        .device_req_o   (dreq),
        .device_addr_o  (daddr),
        .device_we_o    (dwe),
        .device_be_o    (dbe),
        .device_wdata_o (dwdata),
        .device_rvalid_i(drvalid),
        .device_rdata_i (drdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Evaluate this cycle's inputs against the model and check combinational outputs.
    task automatic step();
        int g;
        logic [1:0] elig;
        logic [1:0] exp_gnt;
        logic [69:0] exp_dev, act_dev;
        rsp_t r;
        #1;
        g = -1;
        if (rst) begin
            turn = 0; lock_host = -1; last_host = -1; last_we = 1'b0;
        end else begin
            if (last_host >= 0) begin
                r.vld = (last_host == 1) ? 2'b10 : 2'b01;
                if (last_we) begin
                    r.data = '0; exp_q.push_back(r);
                end else if (drvalid) begin
                    r.data = drdata; exp_q.push_back(r);
                end
            end
            if (lock_host >= 0 && !lock[lock_host]) lock_host = -1;
            elig = req;
            if (lock_host == 0) elig[1] = 1'b0;
            if (lock_host == 1) elig[0] = 1'b0;
            if (elig == 2'b11)      g = turn;
            else if (elig == 2'b01) g = 0;
            else if (elig == 2'b10) g = 1;
            if (g >= 0) begin
                turn = 1 - g;
                if (lock[g]) lock_host = g;
            end
            last_host = g;
            last_we   = (g >= 0) ? we[g] : 1'b0;
        end
        exp_gnt = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
        exp_dev = '0;
        if (g >= 0)
            exp_dev = {1'b1, addr[g*AW +: AW], we[g], be[g*4 +: 4], wdata[g*DW +: DW]};
        act_dev = {dreq, daddr, dwe, dbe, dwdata};
        n_checks++;
        if (gnt !== exp_gnt) begin
            n_fail++;
            $display("FAIL grant t=%0t: got %b, required %b", $time, gnt, exp_gnt);
        end
        n_checks++;
        if (act_dev !== exp_dev) begin
            n_fail++;
            $display("FAIL device_fields t=%0t: got %h, required %h", $time, act_dev, exp_dev);
        end
    endtask

    task automatic tick();
        step();
        @(negedge clk);
    endtask

    task automatic idle();
        req = '0; we = '0; be = '0; addr = '0; wdata = '0; lock = '0;
        drvalid = 1'b0; drdata = '0;
    endtask

    // Monitor: every cycle the response port must match the head of the expectation queue.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            n_checks++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (rvalid !== e.vld || rdata !== e.data) begin
                    n_fail++;
                    $display("FAIL response t=%0t: got vld=%b data=%h, required vld=%b data=%h",
                             $time, rvalid, rdata, e.vld, e.data);
                end
            end else if (rvalid !== 2'b00 || rdata !== '0) begin
                n_fail++;
                $display("FAIL idle_response t=%0t: got vld=%b data=%h, required vld=00 data=0",
                         $time, rvalid, rdata);
            end
        end
    end

    initial begin
        @(negedge clk);
        idle(); rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Host 0 writes 0xA5A5 to OUT; ack next cycle with zero data.
        req = 2'b01; we = 2'b01; be = 8'h0F; addr = '0; wdata = 64'h0000_0000_0000_A5A5;
        tick();
        idle(); tick();

        // Fresh reset, then both hosts read IN continuously: strict alternation from host 0.
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req = (i < 4) ? 2'b11 : 2'b00; we = 2'b00; be = 8'hFF;
            addr = {32'h4, 32'h4};
            drvalid = (i > 0); drdata = $urandom;
            tick();
        end

        // Host 1 reads OUT, device answers 0x1234 once; a repeat rvalid afterwards is ignored.
        idle(); req = 2'b10; addr = {32'h0, 32'h0}; tick();
        idle(); drvalid = 1'b1; drdata = 32'h1234; tick();
        tick();

        // Reset pulse during host 0's read response drops it; host 0 wins first after release.
        idle(); req = 2'b01; tick();
        idle(); rst = 1'b1; drvalid = 1'b1; drdata = 32'hDEAD_BEEF; tick();
        idle(); rst = 1'b0; req = 2'b11; tick();
        idle(); drvalid = 1'b1; drdata = 32'h0000_5555; tick();

        // Spurious device response while idle.
        idle(); drvalid = 1'b1; drdata = 32'h0000_FFFF; tick();
        idle(); tick();

        if (LockEn) begin
            // Host 0 write flips the turn to host 1, then host 1 locks across read + write.
            idle(); req = 2'b01; we = 2'b01; tick();
            idle(); req = 2'b11; lock = 2'b10; drvalid = 1'b0; tick();
            idle(); req = 2'b11; lock = 2'b10; we = 2'b10; drvalid = 1'b1; drdata = 32'h77; tick();
            idle(); req = 2'b11; lock = 2'b10; tick();
            idle(); req = 2'b01; lock = 2'b00; tick();
            idle(); tick();
        end

        // Random traffic with occasional resets and spurious device responses.
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 59) == 0);
            req     = 2'($urandom);
            we      = 2'($urandom);
            be      = 8'($urandom);
            addr    = {32'($urandom_range(0, 4) * 4), 32'($urandom_range(0, 4) * 4)};
            wdata   = {32'($urandom), 32'($urandom)};
            lock    = LockEn ? 2'($urandom & $urandom) : 2'b00;
            drvalid = ($urandom_range(0, 3) != 0);
            drdata  = $urandom;
            tick();
        end
        rst = 1'b0; idle(); tick(); tick();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d undelivered responses, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
